// File: rtl/sample_link_receiver_pkg.sv
`default_nettype none
// ----------------------------------------------------------------
// sample_link_receiver_pkg : shared link constants and FSM states
// Rev 1.0
// ----------------------------------------------------------------
package sample_link_receiver_pkg;

  localparam int c_sample_w = 12;
  localparam int c_depth    = 100;
  localparam int c_cnt_w    = 7;

  typedef enum logic [1:0] {
    S_WAIT_IDLE = 2'd0,
    S_IDLE      = 2'd1,
    S_SHIFT     = 2'd2,
    S_CHECK     = 2'd3
  } link_state_t;

endpackage
`default_nettype wire

// File: rtl/sample_link_receiver_if.sv
`default_nettype none
// ----------------------------------------------------------------
// sample_link_receiver_if : link pins, read port and status flags
// Rev 1.0
// ----------------------------------------------------------------
interface sample_link_receiver_if
  import sample_link_receiver_pkg::*;
#(
  parameter int SAMPLE_W = c_sample_w,
  parameter int CNT_W    = c_cnt_w
) ();

  logic                SCL;
  logic                SS;
  logic                MOSI;
  logic                rd_en;
  logic                err_clr;
  logic [SAMPLE_W-1:0] rd_data;
  logic                rd_valid;
  logic                empty;
  logic                full;
  logic [CNT_W-1:0]    count;
  logic                frame_done;
  logic                frame_err;
  logic                overflow;

  modport master (
    output SCL, SS, MOSI, rd_en, err_clr,
    input  rd_data, rd_valid, empty, full, count, frame_done, frame_err, overflow
  );

  modport slave (
    input  SCL, SS, MOSI, rd_en, err_clr,
    output rd_data, rd_valid, empty, full, count, frame_done, frame_err, overflow
  );

endinterface
`default_nettype wire

// File: rtl/sample_link_receiver_fifo.sv
`default_nettype none
// ----------------------------------------------------------------
// sample_link_receiver_fifo : DEPTH x SAMPLE_W FIFO, registered read
// Rev 1.0
// ----------------------------------------------------------------
module sample_link_receiver_fifo
  import sample_link_receiver_pkg::*;
#(
  parameter int DEPTH    = c_depth,
  parameter int SAMPLE_W = c_sample_w,
  parameter int CNT_W    = c_cnt_w
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [SAMPLE_W-1:0] push_data,
  input  logic                pop_req,
  output logic                push_ok,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic                rd_valid,
  output logic                empty,
  output logic                full,
  output logic [CNT_W-1:0]    count
);

  localparam int                 c_ptr_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);
  localparam logic [CNT_W-1:0]   c_full_cnt = CNT_W'(DEPTH);

  logic [SAMPLE_W-1:0] r_mem [DEPTH];
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [SAMPLE_W-1:0] r_rd_data;
  logic                r_rd_valid;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_full_cnt);
  assign w_pop   = pop_req & ~w_empty;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign w_push  = push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_pop) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign push_ok  = w_push;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign empty    = w_empty;
  assign full     = w_full;
  assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/sample_link_receiver.sv
`default_nettype none
// ----------------------------------------------------------------
// sample_link_receiver : oversampled 3-wire link deserializer + FIFO
// Rev 1.0
// ----------------------------------------------------------------
module sample_link_receiver
  import sample_link_receiver_pkg::*;
#(
  parameter int DEPTH    = c_depth,
  parameter int SAMPLE_W = c_sample_w,
  parameter int CNT_W    = c_cnt_w
) (
  input  logic                 clk,
  input  logic                 rst,
  sample_link_receiver_if.slave bus
);

  localparam int               c_bit_w    = $clog2(SAMPLE_W + 2);
  localparam logic [c_bit_w-1:0] c_bit_max  = c_bit_w'(SAMPLE_W + 1);
  localparam logic [c_bit_w-1:0] c_bit_full = c_bit_w'(SAMPLE_W);

  logic [2:0]          r_scl_sync;
  logic [2:0]          r_ss_sync;
  logic [1:0]          r_mosi_sync;
  link_state_t         r_state;
  logic [SAMPLE_W-1:0] r_shift;
  logic [c_bit_w-1:0]  r_bit_cnt;
  logic                r_frame_done;
  logic                r_frame_err;
  logic                r_overflow;

  logic w_scl_rise;
  logic w_ss_rise;
  logic w_ss_fall;
  logic w_check;
  logic w_len_ok;
  logic w_push;
  logic w_push_ok;
  logic w_len_err;
  logic w_drop;

  // Index 1 is the second flop; index 2 only exists for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scl_sync  <= '0;
      r_ss_sync   <= '0;
      r_mosi_sync <= '0;
    end else begin
      r_scl_sync  <= {r_scl_sync[1:0], bus.SCL};
      r_ss_sync   <= {r_ss_sync[1:0], bus.SS};
      r_mosi_sync <= {r_mosi_sync[0], bus.MOSI};
    end
  end

  assign w_scl_rise = r_scl_sync[1] & ~r_scl_sync[2];
  assign w_ss_rise  = r_ss_sync[1] & ~r_ss_sync[2];
  assign w_ss_fall  = ~r_ss_sync[1] & r_ss_sync[2];

  assign w_check   = (r_state == S_CHECK);
  assign w_len_ok  = (r_bit_cnt == c_bit_full);
  assign w_push    = w_check & w_len_ok;
  assign w_len_err = w_check & ~w_len_ok;
  assign w_drop    = w_push & ~w_push_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_WAIT_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      // A new error in the clearing cycle wins over err_clr.
      r_frame_err  <= (r_frame_err & ~bus.err_clr) | w_len_err;
      r_overflow   <= (r_overflow & ~bus.err_clr) | w_drop;
      case (r_state)
        S_WAIT_IDLE: begin
          if (r_ss_sync[1]) begin
            r_state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (w_ss_fall) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_ss_rise) begin
            r_state <= S_CHECK;
          end else if (w_scl_rise) begin
            r_shift <= {r_shift[SAMPLE_W-2:0], r_mosi_sync[1]};
            if (r_bit_cnt != c_bit_max) begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        S_CHECK: begin
          r_frame_done <= w_push_ok;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_WAIT_IDLE;
      endcase
    end
  end

  sample_link_receiver_fifo #(
    .DEPTH   (DEPTH),
    .SAMPLE_W(SAMPLE_W),
    .CNT_W   (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (w_push),
    .push_data(r_shift),
    .pop_req  (bus.rd_en),
    .push_ok  (w_push_ok),
    .rd_data  (bus.rd_data),
    .rd_valid (bus.rd_valid),
    .empty    (bus.empty),
    .full     (bus.full),
    .count    (bus.count)
  );

  assign bus.frame_done = r_frame_done;
  assign bus.frame_err  = r_frame_err;
  assign bus.overflow   = r_overflow;

endmodule
`default_nettype wire
